// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: Q8.8 format defaults,
// saturation limits, rounding constant and the MAC controller state encoding.
package neuron_pkg;

    localparam int FRAC_BITS_DEF = 8;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    // Half an output LSB expressed in accumulator units; zero when there is no fraction.
    function automatic longint round_half(input int frac_bits);
        return (frac_bits > 0) ? (64'sd1 <<< (frac_bits - 1)) : 64'sd0;
    endfunction

    localparam longint ROUND_HALF_DEF = round_half(FRAC_BITS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_round_sat.sv
// Combinational round-half-up and saturate from a wide signed accumulator
// down to a 16-bit signed fixed-point value.
module neuron_round_sat
    import neuron_pkg::*;
#(
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [15:0]      result
);

    localparam logic signed [ACC_W:0] HALF  = (ACC_W + 1)'(round_half(FRAC_BITS));
    localparam logic signed [ACC_W:0] MAX_W = {{(ACC_W - 15){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W:0] MIN_W = {{(ACC_W - 15){1'b1}}, SAT_MIN};

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    // One guard bit so adding the half-LSB can never wrap the top of the range.
    always_comb begin
        biased  = {acc[ACC_W-1], acc} + HALF;
        shifted = biased >>> FRAC_BITS;
        if (shifted > MAX_W) begin
            result = SAT_MAX;
        end else if (shifted < MIN_W) begin
            result = SAT_MIN;
        end else begin
            result = shifted[15:0];
        end
    end

endmodule

// File: rtl/neuron_mac_accum.sv
// One neuron's pre-activation: bias plus N_INPUTS signed Q8.8 products,
// accumulated one pair per cycle, then rounded and saturated to Q8.8.
module neuron_mac_accum
    import neuron_pkg::*;
#(
    parameter int N_INPUTS  = 8,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_W     = 40
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start,
    input  logic signed [15:0] bias,
    input  logic signed [15:0] inVal,
    input  logic signed [15:0] inWeight,
    input  logic               inValid,
    output logic               inReady,
    output logic signed [15:0] outVal,
    output logic               outValid,
    input  logic               outReady,
    output logic               busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    state_t                   state_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic        [CNT_W-1:0]  cnt_reg;
    logic signed [15:0]       out_val_reg;
    logic                     out_valid_reg;
    logic                     in_ready_reg;

    logic signed [31:0]       product;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [15:0]       rounded;
    logic                     last_pair;

    assign product   = inVal * inWeight;
    assign prod_ext  = {{(ACC_W - 32){product[31]}}, product};
    assign bias_ext  = {{(ACC_W - 16){bias[15]}}, bias};
    assign last_pair = (cnt_reg == CNT_W'(N_INPUTS - 1));

    neuron_round_sat #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc    (acc_reg),
        .result (rounded)
    );

    // inReady and outValid are registered alongside the state so neither
    // has a combinational path from the handshake inputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_val_reg   <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg      <= bias_ext <<< FRAC_BITS;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b1;
                        state_reg    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (inValid) begin
                        acc_reg <= acc_reg + prod_ext;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (last_pair) begin
                            in_ready_reg <= 1'b0;
                            state_reg    <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    out_val_reg   <= rounded;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (outReady) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign inReady  = in_ready_reg;
    assign outVal   = out_val_reg;
    assign outValid = out_valid_reg;
    assign busy     = (state_reg != IDLE);

endmodule
